// File: rtl/frame_renderer_if.sv
// Bus between the game datapath (master) and frame_renderer (slave):
// frame control, sprite position, bitmap RAM read port and pixel output.
interface frame_renderer_if #(
  parameter int unsigned COORD_W  = 8,
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned COLOUR_W = 3
);
  logic                start;
  logic [COORD_W-1:0]  sprite_x;
  logic [COORD_W-1:0]  sprite_y;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_data;
  logic [COORD_W-1:0]  x;
  logic [COORD_W-1:0]  y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                done;

  modport master (
    output start, sprite_x, sprite_y, rd_data,
    input  rd_addr, x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, sprite_x, sprite_y, rd_data,
    output rd_addr, x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/frame_renderer.sv
// Frame renderer: scans a column-major 1-bit playfield bitmap from a
// 1-cycle synchronous RAM, emits one VGA pixel per cycle, then overlays
// a clipped rectangular sprite and pulses done.
// Pipeline: s0 = issued coordinate (and RAM address), s1 = RAM data
// returning, output stage = registered x/y/colour/plot.
module frame_renderer #(
  parameter int unsigned MAP_W    = 120,
  parameter int unsigned MAP_H    = 100,
  parameter int unsigned X_OFF    = 20,
  parameter int unsigned Y_OFF    = 10,
  parameter int unsigned SPR_W    = 4,
  parameter int unsigned SPR_H    = 6,
  parameter int unsigned COORD_W  = 8,
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned COLOUR_W = 3,
  parameter logic [COLOUR_W-1:0] FG_COLOUR  = 3'b111,
  parameter logic [COLOUR_W-1:0] BG_COLOUR  = 3'b000,
  parameter logic [COLOUR_W-1:0] SPR_COLOUR = 3'b100
) (
  input logic              clk,
  input logic              resetn,
  frame_renderer_if.slave  bus
);

  localparam int unsigned N_PIX    = MAP_W * MAP_H;
  localparam int unsigned ADDR_PRE = (N_PIX > 1) ? (N_PIX - 2) : 0;
  localparam int unsigned CW1      = COORD_W + 1;

  typedef enum logic [1:0] {IDLE, WALL, SPRITE, FINISH} state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [COORD_W-1:0]  r_sx;
  logic [COORD_W-1:0]  r_sy;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [COORD_W-1:0]  r_spr_i;
  logic [COORD_W-1:0]  r_spr_j;
  logic                r_spr_end;

  logic                r_s0_vld;
  logic                r_s0_spr;
  logic                r_s0_vis;
  logic [COORD_W-1:0]  r_s0_px;
  logic [COORD_W-1:0]  r_s0_py;

  logic                r_s1_vld;
  logic                r_s1_spr;
  logic                r_s1_vis;
  logic [COORD_W-1:0]  r_s1_px;
  logic [COORD_W-1:0]  r_s1_py;

  logic [COORD_W-1:0]  r_x;
  logic [COORD_W-1:0]  r_y;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_plot;
  logic                r_busy;
  logic                r_done;

  logic [CW1-1:0]      w_spr_px;
  logic [CW1-1:0]      w_spr_py;
  logic                w_spr_vis;
  logic                w_last_i;
  logic                w_last_j;
  logic                w_wall_last_row;

  // Sprite pixel position is formed one bit wider so the clip test cannot wrap.
  assign w_spr_px        = CW1'(r_sx) + CW1'(r_spr_i);
  assign w_spr_py        = CW1'(r_sy) + CW1'(r_spr_j);
  assign w_spr_vis       = (w_spr_px < CW1'(MAP_W)) && (w_spr_py < CW1'(MAP_H));
  assign w_last_i        = (r_spr_i == COORD_W'(SPR_W - 1));
  assign w_last_j        = (r_spr_j == COORD_W'(SPR_H - 1));
  assign w_wall_last_row = (r_s0_py == COORD_W'(MAP_H - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; SPRITE also covers the two-cycle pipeline drain.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = (N_PIX > 1) ? WALL : SPRITE;
      WALL:    if (r_rd_addr == ADDR_W'(ADDR_PRE)) w_state_nxt = SPRITE;
      SPRITE:  if (r_spr_end && !r_s0_vld && !r_s1_vld) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Issue stage: bitmap address / wall col,row, then sprite i,j with clip flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sx      <= '0;
      r_sy      <= '0;
      r_rd_addr <= '0;
      r_spr_i   <= '0;
      r_spr_j   <= '0;
      r_spr_end <= 1'b0;
      r_s0_vld  <= 1'b0;
      r_s0_spr  <= 1'b0;
      r_s0_vis  <= 1'b0;
      r_s0_px   <= '0;
      r_s0_py   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_s0_vld <= 1'b0;
          if (bus.start) begin
            r_sx      <= bus.sprite_x;
            r_sy      <= bus.sprite_y;
            r_rd_addr <= '0;
            r_spr_i   <= '0;
            r_spr_j   <= '0;
            r_spr_end <= 1'b0;
            r_s0_vld  <= 1'b1;
            r_s0_spr  <= 1'b0;
            r_s0_vis  <= 1'b1;
            r_s0_px   <= '0;
            r_s0_py   <= '0;
          end
        end
        WALL: begin
          r_rd_addr <= r_rd_addr + ADDR_W'(1);
          r_s0_vld  <= 1'b1;
          if (w_wall_last_row) begin
            r_s0_py <= '0;
            r_s0_px <= r_s0_px + COORD_W'(1);
          end else begin
            r_s0_py <= r_s0_py + COORD_W'(1);
          end
        end
        SPRITE: begin
          if (!r_spr_end) begin
            r_s0_vld <= 1'b1;
            r_s0_spr <= 1'b1;
            r_s0_vis <= w_spr_vis;
            r_s0_px  <= w_spr_px[COORD_W-1:0];
            r_s0_py  <= w_spr_py[COORD_W-1:0];
            if (w_last_j) begin
              r_spr_j <= '0;
              if (w_last_i) r_spr_end <= 1'b1;
              else          r_spr_i   <= r_spr_i + COORD_W'(1);
            end else begin
              r_spr_j <= r_spr_j + COORD_W'(1);
            end
          end else begin
            r_s0_vld <= 1'b0;
          end
        end
        default: r_s0_vld <= 1'b0;
      endcase
    end
  end

  // RAM-return stage and registered pixel/status outputs; x/y/colour hold when not plotting.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_s1_vld <= 1'b0;
      r_s1_spr <= 1'b0;
      r_s1_vis <= 1'b0;
      r_s1_px  <= '0;
      r_s1_py  <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= BG_COLOUR;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_s1_vld <= r_s0_vld;
      r_s1_spr <= r_s0_spr;
      r_s1_vis <= r_s0_vis;
      r_s1_px  <= r_s0_px;
      r_s1_py  <= r_s0_py;
      r_plot   <= r_s1_vld && r_s1_vis;
      if (r_s1_vld && r_s1_vis) begin
        r_x      <= COORD_W'(X_OFF) + r_s1_px;
        r_y      <= COORD_W'(Y_OFF) + r_s1_py;
        r_colour <= r_s1_spr ? SPR_COLOUR : (bus.rd_data ? FG_COLOUR : BG_COLOUR);
      end
      r_busy <= (w_state_nxt == WALL) || (w_state_nxt == SPRITE);
      r_done <= (w_state_nxt == FINISH);
    end
  end

  assign bus.rd_addr = r_rd_addr;
  assign bus.x       = r_x;
  assign bus.y       = r_y;
  assign bus.colour  = r_colour;
  assign bus.plot    = r_plot;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

// File: doc/frame_renderer.md
Name: frame_renderer

Overview:
- Parametrised successor to the fixed 120x100 wall/dude screen updater.
- On a start pulse, scans a column-major 1-bit playfield bitmap held in an external synchronous RAM and emits one VGA-adapter pixel per cycle.
- After the playfield, overlays a rectangular sprite with clipping, then pulses done.
- Sits between the game datapath (owns bitmap RAM, sprite position) and the 160x120 vga_adapter; done feeds the control FSM in place of the old `o` flag.

Parameters:
- MAP_W, 120, playfield columns.
- MAP_H, 100, playfield rows.
- X_OFF, 20, screen x of playfield column 0.
- Y_OFF, 10, screen y of playfield row 0.
- SPR_W, 4, sprite width in pixels.
- SPR_H, 6, sprite height in pixels.
- COORD_W, 8, width of x/y/sprite coordinates.
- ADDR_W, 14, bitmap RAM address width; must satisfy 2^ADDR_W >= MAP_W*MAP_H.
- COLOUR_W, 3, colour width.
- FG_COLOUR, 3'b111, colour of a set bitmap bit.
- BG_COLOUR, 3'b000, colour of a clear bitmap bit.
- SPR_COLOUR, 3'b100, sprite colour.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- start  in  1  begin a frame; sampled only in IDLE.
- sprite_x  in  COORD_W  sprite left column in playfield coordinates; latched at start.
- sprite_y  in  COORD_W  sprite top row in playfield coordinates; latched at start.
- rd_addr  out  ADDR_W  bitmap read address = col*MAP_H + row.
- rd_data  in  1  bitmap bit; valid the cycle after rd_addr is registered (1-cycle synchronous RAM).
- x  out  COORD_W  screen x of the current pixel.
- y  out  COORD_W  screen y of the current pixel.
- colour  out  COLOUR_W  pixel colour.
- plot  out  1  pixel write strobe.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Clock and reset: one clock `clk`; reset `resetn` is synchronous and active-low.
- Reset values: busy=0, done=0, plot=0, x=0, y=0, colour=BG_COLOUR, rd_addr=0; FSM returns to IDLE.
- Reset mid-frame aborts the frame immediately; no done pulse is produced.
- FSM states: IDLE, WALL, SPRITE, FINISH.
  - IDLE: on start=1 at edge 0, latch sprite_x/sprite_y, set col=row=0, rd_addr=0, go to WALL.
  - WALL: each edge, advance row (wrapping to 0 and incrementing col at MAP_H-1) and rd_addr += 1. After the address for (MAP_W-1, MAP_H-1) is issued, go to SPRITE.
  - SPRITE: iterate i over 0..SPR_W-1 (outer) and j over 0..SPR_H-1 (inner), one per cycle. After the last pixel, go to FINISH.
  - FINISH: pulse done for one cycle, drop busy, return to IDLE.
- Scan order: column-major, x outer, y inner; matches the bitmap layout.
- Pipeline: wall pixel k (address k) appears on x/y/colour with plot=1 in the cycle after edge k+2.
  - x = X_OFF + col, y = Y_OFF + row.
  - colour = rd_data ? FG_COLOUR : BG_COLOUR.
  - col/row travel with the pipeline; they are not recomputed from the address.
- Sprite pixel m (m = i*SPR_H + j) appears after edge N+2+m, where N = MAP_W*MAP_H.
  - x = X_OFF + sx + i, y = Y_OFF + sy + j, colour = SPR_COLOUR.
- Clipping: a sprite pixel with sx+i >= MAP_W or sy+j >= MAP_H still consumes its cycle but has plot=0. Compute the comparisons at COORD_W+1 bits so sums cannot wrap.
- Timing: done=1 in the cycle after edge N+S+2, where S = SPR_W*SPR_H. Frame length is fixed regardless of data or clipping.
- plot is 0 in IDLE, in FINISH, and in the first pipeline-fill cycle.
- x/y/colour hold their last values while plot=0.
- start while busy: ignored and not queued. start in the done cycle: ignored. start is accepted again from the first IDLE cycle.
- sprite_x/sprite_y changes during a frame have no effect until the next start.
- rd_addr holds its last value outside WALL.

Test Plan:
- Reset, then idle with MAP_W=4, MAP_H=3, SPR_W=SPR_H=2, X_OFF=20, Y_OFF=10 -> all outputs at reset values; no plot for 50 cycles.
- Same config, RAM with only bit 4 set (col 1, row 1), start with sprite (0,0) -> rd_addr steps 0..11 on consecutive cycles.
  - 12 wall plots in column-major order; only (21,11) is 3'b111, the rest 3'b000.
  - Then sprite plots (20,10),(20,11),(21,10),(21,11) in 3'b100.
  - done pulses exactly 18 cycles after the start edge; busy falls with it.
- Sprite at (3,2) in the same config -> only (23,12) is plotted in sprite colour; the other three sprite cycles have plot=0; done is still at cycle 18.
- Start re-asserted at cycles 5 and 18 of a frame -> ignored; busy=0 for at least one cycle.
  - A start at cycle 19 begins a new frame, and its done arrives 18 cycles later.
- resetn=0 at cycle 7 mid-WALL -> next cycle plot=0, busy=0, rd_addr=0; no done pulse.
  - A subsequent start produces a full, correct frame.
- Default parameters, full-ones bitmap, sprite (118,98) -> 12000 FG plots.
  - Sprite plots only at (138,108),(139,108),(138,109),(139,109); the other 20 sprite cycles have plot=0.
  - done at cycle 12026.
